// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types.
// Arbiter FSM states, master index, master count.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef logic midx_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// On contention the master not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  midx_t      last,
  output midx_t      grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = last;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = last;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master sequencer for the shared SRAM/VGA decoder port.
// Setup / strobe / hold phasing with registered active-low strobes.
module mem_arbiter #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_in,
  output logic        mem_n_we,
  output logic        mem_n_oe,
  input  logic [31:0] mem_out
);

  import mem_arb_pkg::*;

  localparam int CW =
    (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  midx_t win_q, last_q, grant;
  logic gvalid, we_q, bad_q;
  logic [NUM_MASTERS-1:0] req;
  logic [31:0] sel_addr;

  assign req = {m1_req, m0_req};
  assign sel_addr = grant ? m1_addr : m0_addr;

  rr_arb2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (grant),
    .valid (gvalid)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gvalid) state_d = SETUP;
      SETUP:   state_d = bad_q ? HOLD : STROBE;
      STROBE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_addr <= '0;
      mem_in   <= '0;
      rdata    <= '0;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      if (state_q == IDLE && gvalid) begin
        mem_addr <= sel_addr;
        mem_in   <= grant ? m1_wdata : m0_wdata;
        we_q     <= grant ? m1_we : m0_we;
        bad_q    <= sel_addr[1:0] != 2'b00;
        win_q    <= grant;
        last_q   <= grant;
      end
      if (state_q == SETUP)
        cnt_q <= CW'(STROBE_CYCLES - 1);
      if (state_q == STROBE) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else if (!we_q)  rdata <= mem_out;
      end
    end
  end

  // Strobes are registered so they never glitch at the decoder.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_n_we <= 1'b1;
      mem_n_oe <= 1'b1;
    end else begin
      mem_n_we <= !(state_d == STROBE && we_q);
      mem_n_oe <= !(state_d == STROBE && !we_q);
    end
  end

  assign m0_ack = (state_q == HOLD) && !win_q;
  assign m1_ack = (state_q == HOLD) && win_q;
  assign err    = (state_q == HOLD) && bad_q;

  a_strobe_excl: assert property (
    @(posedge clk) disable iff (!n_rst)
    mem_n_we || mem_n_oe);

  a_ack_onehot: assert property (
    @(posedge clk) disable iff (!n_rst)
    !(m0_ack && m1_ack));

  a_grant_req: assert property (
    @(posedge clk) disable iff (!n_rst)
    (state_q == IDLE && gvalid) |-> req[grant]);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Vector table, corner sequences, random run against a countdown model.
module tb_mem_arbiter;

  localparam int SC  = 1;
  localparam int SC3 = 3;
  localparam logic [31:0] K = 32'hA5A5_5A5A;

  logic clk = 0;
  logic n_rst = 0;
  logic m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic m0_ack, m1_ack, err, mem_n_we, mem_n_oe;
  logic [31:0] rdata, mem_addr, mem_in, mem_out;
  logic [31:0] mout_r = 0;
  logic use_fn = 0;

  logic n_rst3 = 0, m0_req3 = 0;
  logic m0_ack3, m1_ack3, err3, n_we3, n_oe3;
  logic [31:0] rdata3, addr3, in3;

  int total = 0;
  int bad = 0;

  assign mem_out = use_fn ? (mem_addr ^ K) : mout_r;

  always #5 clk = ~clk;

  mem_arbiter #(.STROBE_CYCLES(SC)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_n_we(mem_n_we), .mem_n_oe(mem_n_oe),
    .mem_out(mem_out)
  );

  mem_arbiter #(.STROBE_CYCLES(SC3)) u_dut3 (
    .clk(clk), .n_rst(n_rst3),
    .m0_req(m0_req3), .m1_req(1'b0),
    .m0_we(1'b0), .m1_we(1'b0),
    .m0_addr(32'h0000_0300), .m1_addr(32'h0),
    .m0_wdata(32'h0), .m1_wdata(32'h0),
    .m0_ack(m0_ack3), .m1_ack(m1_ack3), .err(err3),
    .rdata(rdata3), .mem_addr(addr3), .mem_in(in3),
    .mem_n_we(n_we3), .mem_n_oe(n_oe3),
    .mem_out(32'h55AA_1234)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    m0_req = 0;
    m1_req = 0;
    n_rst = 0;
    repeat (2) tick();
    n_rst = 1;
  endtask

  typedef struct {
    bit m;
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mout;
    logic [31:0] rd;
    bit e;
    int lat;
    int oe_lo;
    int we_lo;
  } vec_t;

  vec_t v[6];

  initial begin
    v[0] = '{0, 0, 32'h0000_0100, 32'h0,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 3, 1, 0};
    v[1] = '{1, 1, 32'h0001_0040, 32'h1234_5678,
             32'h0, 32'hDEAD_BEEF, 0, 3, 0, 1};
    v[2] = '{0, 0, 32'h0000_0102, 32'h0,
             32'h1111_1111, 32'hDEAD_BEEF, 1, 2, 0, 0};
    v[3] = '{1, 0, 32'h0001_0044, 32'h0,
             32'hCAFE_F00D, 32'hCAFE_F00D, 0, 3, 1, 0};
    v[4] = '{0, 1, 32'h0000_0001, 32'h7777_7777,
             32'h0, 32'hCAFE_F00D, 1, 2, 0, 0};
    v[5] = '{1, 1, 32'h0001_0003, 32'h8888_8888,
             32'h0, 32'hCAFE_F00D, 1, 2, 0, 0};

    do_reset();
    n_rst3 = 1;
    chk("rst_strobes", {mem_n_we, mem_n_oe}, 2'b11);
    chk("rst_addr", mem_addr, 0);
    chk("rst_in", mem_in, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", {m0_ack, m1_ack, err}, 0);

    for (int i = 0; i < 6; i++) begin
      int oel, wel, lat, astab;
      logic ae, oa;
      logic [31:0] min;
      oel = 0; wel = 0; lat = 0; astab = 0;
      ae = 0; oa = 0; min = 0;
      mout_r = v[i].mout;
      if (v[i].m) begin
        m1_req = 1; m1_we = v[i].we;
        m1_addr = v[i].addr; m1_wdata = v[i].wdata;
      end else begin
        m0_req = 1; m0_we = v[i].we;
        m0_addr = v[i].addr; m0_wdata = v[i].wdata;
      end
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        tick();
        if (!mem_n_oe) oel++;
        if (!mem_n_we) wel++;
        if (mem_addr !== v[i].addr) astab++;
        if (v[i].m ? m1_ack : m0_ack) begin
          lat = c;
          ae = err;
          oa = v[i].m ? m0_ack : m1_ack;
          min = mem_in;
        end
      end
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_err", i), ae, v[i].e);
      chk($sformatf("v%0d_other", i), oa, 0);
      chk($sformatf("v%0d_rdata", i), rdata, v[i].rd);
      chk($sformatf("v%0d_oe", i), oel, v[i].oe_lo);
      chk($sformatf("v%0d_we", i), wel, v[i].we_lo);
      chk($sformatf("v%0d_astab", i), astab, 0);
      if (v[i].we && !v[i].e)
        chk($sformatf("v%0d_min", i), min, v[i].wdata);
      m0_req = 0;
      m1_req = 0;
      tick();
    end

    // contention from reset: M0 first, then alternate
    begin
      int order[$];
      do_reset();
      m0_we = 0; m0_addr = 32'h10;
      m1_we = 0; m1_addr = 32'h0001_0020;
      m0_req = 1;
      m1_req = 1;
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
        tick();
        chk("rr_onehot", m0_ack & m1_ack, 0);
        if (m0_ack) order.push_back(0);
        if (m1_ack) order.push_back(1);
      end
      chk("rr_count", order.size(), 4);
      for (int j = 0; j < order.size(); j++)
        chk($sformatf("rr_%0d", j), order[j], j % 2);
      m0_req = 0;
      m1_req = 0;
      repeat (6) tick();
    end

    // M0 drops REQ during STROBE
    begin
      int acks, lows;
      acks = 0; lows = 0;
      mout_r = 32'h0BAD_F00D;
      m0_we = 0; m0_addr = 32'h200;
      m0_req = 1;
      tick();
      tick();
      chk("drop_oe", mem_n_oe, 0);
      m0_req = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (m0_ack) acks++;
        if (c > 0 && !(mem_n_oe && mem_n_we)) lows++;
      end
      chk("drop_acks", acks, 1);
      chk("drop_idle", lows, 0);
      chk("drop_rdata", rdata, 32'h0BAD_F00D);
    end

    // STROBE_CYCLES=3, async reset mid-strobe
    begin
      int lat, oel;
      lat = 0; oel = 0;
      m0_req3 = 1;
      tick();
      tick();
      chk("r3_oe_low", n_oe3, 0);
      #2 n_rst3 = 0;
      #1;
      chk("r3_strobes", {n_we3, n_oe3}, 2'b11);
      chk("r3_ack", {m0_ack3, m1_ack3, err3}, 0);
      chk("r3_rdata", rdata3, 0);
      m0_req3 = 0;
      tick();
      tick();
      n_rst3 = 1;
      m0_req3 = 1;
      for (int c = 1; c <= 12 && lat == 0; c++) begin
        tick();
        if (!n_oe3) oel++;
        if (m0_ack3) lat = c;
      end
      chk("r3_lat", lat, SC3 + 2);
      chk("r3_oecnt", oel, SC3);
      chk("r3_rd", rdata3, 32'h55AA_1234);
      chk("r3_err", err3, 0);
      m0_req3 = 0;
    end

    // randomized run against a transaction countdown model
    begin
      int rem, len;
      bit ptr, win, mwe, mbad, e0, e1;
      logic [31:0] maddr, mwd, mrd;
      use_fn = 1;
      do_reset();
      rem = 0; len = 0; ptr = 1; win = 0;
      mwe = 0; mbad = 0; maddr = 0; mwd = 0; mrd = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (rem == 0) begin
          if (m0_req || m1_req) begin
            win = (m0_req && m1_req) ? ~ptr : m1_req;
            ptr = win;
            maddr = win ? m1_addr : m0_addr;
            mwd = win ? m1_wdata : m0_wdata;
            mwe = win ? m1_we : m0_we;
            mbad = maddr[1:0] != 0;
            len = mbad ? 2 : SC + 2;
            rem = len;
          end
        end else begin
          rem--;
        end
        if (rem == 1 && !mwe && !mbad) mrd = maddr ^ K;
        tick();
        e0 = rem == 1 && !win;
        e1 = rem == 1 && win;
        chk("rnd_ack", {m0_ack, m1_ack, err},
            {e0, e1, rem == 1 && mbad});
        chk("rnd_strobe", {mem_n_we, mem_n_oe},
            {!(rem >= 2 && rem < len && !mbad && mwe),
             !(rem >= 2 && rem < len && !mbad && !mwe)});
        chk("rnd_rdata", rdata, mrd);
        if (rem > 0) chk("rnd_addr", mem_addr, maddr);
        if (rem > 0 && mwe) chk("rnd_min", mem_in, mwd);
        if (e0) m0_req = 0;
        if (e1) m1_req = 0;
        if (!m0_req && $urandom_range(2) == 0) begin
          m0_req = 1;
          m0_we = $urandom_range(1);
          m0_addr = $urandom & 32'h0001_FFFC;
          if ($urandom_range(3) == 0) m0_addr[1:0] = 2'($urandom_range(1, 3));
          m0_wdata = $urandom;
        end
        if (!m1_req && $urandom_range(2) == 0) begin
          m1_req = 1;
          m1_we = $urandom_range(1);
          m1_addr = $urandom & 32'h0001_FFFC;
          if ($urandom_range(3) == 0) m1_addr[1:0] = 2'($urandom_range(1, 3));
          m1_wdata = $urandom;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
